// File: rtl/sv_switch_debouncer.sv
// Switch conditioning: per-channel synchroniser, debounce FSM and edge pulses.
// Optional DEBOUNCER_TOGGLE_EN: clean_out toggles on each accepted rise.

module sv_switch_debouncer_ch #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic {IDLE, CHECK} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   stable;
    logic                   s;
    logic                   accept;

    assign s      = sync[SYNC_STAGES-1];
    assign accept = (state == CHECK) && (s != stable) &&
                    (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) sync <= '0;
        else          sync <= {sync[SYNC_STAGES-2:0], raw};
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                IDLE: begin
                    if (s != stable) begin
                        state <= CHECK;
                        cnt   <= CW'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                CHECK: begin
                    if (s == stable) begin
                        // bounce back to the accepted level: drop the attempt
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (accept) begin
                        stable <= s;
                        rise   <= s;
                        fall   <= ~s;
                        state  <= IDLE;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef DEBOUNCER_TOGGLE_EN
    always_ff @(posedge clock) begin
        if (!reset_n)          clean <= 1'b0;
        else if (accept && s)  clean <= ~clean;
    end
`else
    assign clean = stable;
`endif

endmodule

module sv_switch_debouncer #(
    parameter int NUM_INPUTS      = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_INPUTS-1:0] raw_in,
    output logic [NUM_INPUTS-1:0] clean_out,
    output logic [NUM_INPUTS-1:0] rise_pulse,
    output logic [NUM_INPUTS-1:0] fall_pulse
);
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
        sv_switch_debouncer_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clock  (clock),
            .reset_n(reset_n),
            .raw    (raw_in[i]),
            .clean  (clean_out[i]),
            .rise   (rise_pulse[i]),
            .fall   (fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_sv_switch_debouncer.sv
// Scoreboard bench for sv_switch_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_sv_switch_debouncer;
    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int DB   = 4;

    typedef struct packed {
        logic [N-1:0] clean;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] raw_in = '0;
    logic [N-1:0] clean_out, rise_pulse, fall_pulse;

    int n_chk = 0;
    int n_fail = 0;
    int rise_tot [N];
    int fall_tot [N];

    exp_t         sb_q[$];
    logic [N-1:0] m_hist [SYNC];
    logic [N-1:0] m_stable, m_clean;
    int           m_run [N];

    sv_switch_debouncer #(.NUM_INPUTS(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .raw_in    (raw_in),
        .clean_out (clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a level is accepted once the synchronised input has differed
    // from the accepted level on DB consecutive edges.
    task automatic model_edge(output exp_t e);
        logic [N-1:0] s;
        e = '0;
        if (!reset_n) begin
            for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
            m_stable = '0;
            m_clean  = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            s = m_hist[SYNC-1];
            for (int i = 0; i < N; i++) begin
                if (s[i] != m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_run[i]    = 0;
                        m_stable[i] = s[i];
                        if (s[i]) begin
                            e.rise[i] = 1'b1;
`ifdef DEBOUNCER_TOGGLE_EN
                            m_clean[i] = ~m_clean[i];
`endif
                        end else begin
                            e.fall[i] = 1'b1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            for (int k = SYNC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = raw_in;
`ifndef DEBOUNCER_TOGGLE_EN
            m_clean = m_stable;
`endif
        end
        e.clean = m_clean;
    endtask

    task automatic step();
        exp_t e;
        model_edge(e);
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        chk("clean", 32'(clean_out), 32'(e.clean));
        chk("rise", 32'(rise_pulse), 32'(e.rise));
        chk("fall", 32'(fall_pulse), 32'(e.fall));
        chk("excl", 32'(rise_pulse & fall_pulse), 32'd0);
        for (int i = 0; i < N; i++) begin
            rise_tot[i] += int'(rise_pulse[i]);
            fall_tot[i] += int'(fall_pulse[i]);
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    function automatic int pulse_sum();
        int t = 0;
        for (int i = 0; i < N; i++) t += rise_tot[i] + fall_tot[i];
        return t;
    endfunction

    initial begin
        int base;
        int r2;
        for (int i = 0; i < N; i++) begin rise_tot[i] = 0; fall_tot[i] = 0; end

        // reset held with all switches high
        raw_in = 4'b1111; reset_n = 1'b0;
        steps(3);
        chk("rst_clean", 32'(clean_out), 32'd0);
        reset_n = 1'b1;
        steps(5);
        chk("rst_lat5", 32'(clean_out), 32'd0);
        step();
        chk("rst_clean6", 32'(clean_out), 32'hF);
        chk("rst_rise6", 32'(rise_pulse), 32'hF);
        step();
        chk("rst_rise7", 32'(rise_pulse), 32'd0);
        raw_in = '0; steps(8);

        // single step on channel 0
        raw_in = 4'b0001;
        steps(5);
        chk("step_r5", 32'(rise_pulse), 32'd0);
        step();
        chk("step_r6", 32'(rise_pulse), 32'h1);
        chk("step_f6", 32'(fall_pulse), 32'd0);
        step();
        chk("step_r7", 32'(rise_pulse), 32'd0);
        raw_in = '0; steps(8);

        // bounce on channel 2
        r2 = rise_tot[2];
        raw_in = 4'b0100; step();
        raw_in = 4'b0000; step();
        raw_in = 4'b0100; step();
        raw_in = 4'b0000; step();
        raw_in = 4'b0100; steps(10);
        chk("bounce_rises", 32'(rise_tot[2] - r2), 32'd1);
        raw_in = '0; steps(8);

        // 3-cycle glitch on channel 3
        base = pulse_sum();
        raw_in = 4'b1000; steps(3);
        raw_in = 4'b0000; steps(8);
        chk("glitch_pulses", 32'(pulse_sum() - base), 32'd0);

        // simultaneous transitions
        raw_in = 4'b1010; steps(8);
        raw_in = 4'b0101; steps(5);
        step();
        chk("simul_fall", 32'(fall_pulse), 32'hA);
        chk("simul_rise", 32'(rise_pulse), 32'h5);
        raw_in = '0; steps(8);

        // reset mid-qualification on channel 1
        base = pulse_sum();
        raw_in = 4'b0010; steps(3);
        reset_n = 1'b0; step();
        reset_n = 1'b1; steps(5);
        chk("midrst_pulses", 32'(pulse_sum() - base), 32'd0);
        step();
        chk("midrst_rise", 32'(rise_pulse), 32'h2);
        chk("midrst_clean1", 32'(clean_out[1]), 32'd1);

        // two presses on channel 0 from a fresh reset
        raw_in = '0; reset_n = 1'b0; steps(2);
        reset_n = 1'b1;
        base = fall_tot[0];
        raw_in = 4'b0001; steps(8);
        chk("tog_p1", 32'(clean_out[0]), 32'd1);
        raw_in = 4'b0000; steps(8);
`ifdef DEBOUNCER_TOGGLE_EN
        chk("tog_r1", 32'(clean_out[0]), 32'd1);
`else
        chk("tog_r1", 32'(clean_out[0]), 32'd0);
`endif
        raw_in = 4'b0001; steps(8);
`ifdef DEBOUNCER_TOGGLE_EN
        chk("tog_p2", 32'(clean_out[0]), 32'd0);
`else
        chk("tog_p2", 32'(clean_out[0]), 32'd1);
`endif
        raw_in = 4'b0000; steps(8);
        chk("tog_r2", 32'(clean_out[0]), 32'd0);
        chk("tog_falls", 32'(fall_tot[0] - base), 32'd2);

        // random bouncing with occasional resets
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(5) == 0) raw_in[i] = ~raw_in[i];
            reset_n = ($urandom_range(99) != 0);
            step();
        end
        reset_n = 1'b1;
        steps(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
